// File: rtl/tag_array_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tag_array_pkg
//  Brief    : Shared geometry and FSM state type for the tag array controller.
//  Revision : 1.0 - initial release
// ============================================================================
package tag_array_pkg;

    localparam int SETS      = 512;
    localparam int IDX_W     = 9;
    localparam int WAYS      = 4;
    localparam int TAG_W     = 19;
    localparam int VALID_BIT = 18;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tag_array_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : tag_array_ctrl_if
//  Brief    : Client-side lookup / refill / flush bus of the tag array controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface tag_array_ctrl_if;
    import tag_array_pkg::*;

    logic                      lk_valid;
    logic                      lk_ready;
    logic [IDX_W-1:0]          lk_idx;
    logic [TAG_W-2:0]          lk_tag;
    logic                      lk_resp_valid;
    logic [WAYS*TAG_W-1:0]     lk_resp_data;
    logic [WAYS-1:0]           lk_hit_oh;

    logic                      wr_valid;
    logic                      wr_ready;
    logic [IDX_W-1:0]          wr_idx;
    logic [WAYS-1:0]           wr_way_oh;
    logic [TAG_W-1:0]          wr_data;

    logic                      fl_valid;
    logic                      fl_ready;
    logic                      init_done;

    modport master (
        output lk_valid, lk_idx, lk_tag,
        input  lk_ready, lk_resp_valid, lk_resp_data, lk_hit_oh,
        output wr_valid, wr_idx, wr_way_oh, wr_data,
        input  wr_ready,
        output fl_valid,
        input  fl_ready, init_done
    );

    modport slave (
        input  lk_valid, lk_idx, lk_tag,
        output lk_ready, lk_resp_valid, lk_resp_data, lk_hit_oh,
        input  wr_valid, wr_idx, wr_way_oh, wr_data,
        output wr_ready,
        input  fl_valid,
        output fl_ready, init_done
    );

endinterface
`default_nettype wire

// File: rtl/tag_way_compare.sv
`default_nettype none
// ============================================================================
//  Module   : tag_way_compare
//  Brief    : Combinational valid-and-tag match for one way of a set.
//  Revision : 1.0 - initial release
// ============================================================================
module tag_way_compare
    import tag_array_pkg::*;
(
    input  wire logic [TAG_W-1:0] i_entry,
    input  wire logic [TAG_W-2:0] i_tag,
    output logic                  o_hit
);

    assign o_hit = i_entry[VALID_BIT] && (i_entry[TAG_W-2:0] == i_tag);

endmodule
`default_nettype wire

// File: rtl/tag_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tag_array_ctrl
//  Brief    : Invalidation sweeps, lookups and refill writes for the 4-way tag
//             SRAM, with same-cycle write-to-read forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
module tag_array_ctrl
    import tag_array_pkg::*;
(
    input  wire logic              clock,
    input  wire logic              reset,
    tag_array_ctrl_if.slave        bus,
    output logic [IDX_W-1:0]       sram_r_addr,
    input  wire logic [TAG_W-1:0]  sram_r_data_0,
    input  wire logic [TAG_W-1:0]  sram_r_data_1,
    input  wire logic [TAG_W-1:0]  sram_r_data_2,
    input  wire logic [TAG_W-1:0]  sram_r_data_3,
    output logic                   sram_w_en,
    output logic [IDX_W-1:0]       sram_w_addr,
    output logic [TAG_W-1:0]       sram_w_data_0,
    output logic [TAG_W-1:0]       sram_w_data_1,
    output logic [TAG_W-1:0]       sram_w_data_2,
    output logic [TAG_W-1:0]       sram_w_data_3,
    output logic [WAYS-1:0]        sram_w_maskOH
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(SETS - 1);

    state_t                r_state;
    logic [IDX_W-1:0]      r_sweep_idx;

    logic                  r_resp_valid;
    logic [TAG_W-2:0]      r_lk_tag;
    logic [WAYS-1:0]       r_fwd_mask;
    logic [TAG_W-1:0]      r_fwd_data;

    logic                  w_run;
    logic                  w_fl_acc;
    logic                  w_lk_acc;
    logic                  w_wr_acc;
    logic [TAG_W-1:0]      w_wr_word;
    logic [TAG_W-1:0]      w_rd_data [WAYS];
    logic [WAYS*TAG_W-1:0] w_resp_data;
    logic [WAYS-1:0]       w_hit;

    assign w_run    = (r_state == RUN);
    assign w_fl_acc = w_run && bus.fl_valid;
    assign w_lk_acc = w_run && !bus.fl_valid && bus.lk_valid;
    assign w_wr_acc = w_run && !bus.fl_valid && bus.wr_valid;

    assign bus.fl_ready  = w_run;
    assign bus.lk_ready  = w_run && !bus.fl_valid;
    assign bus.wr_ready  = w_run && !bus.fl_valid;
    assign bus.init_done = w_run;

    // Sweep sequencing: one set invalidated per cycle, flush restarts from 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= INIT;
            r_sweep_idx <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_sweep_idx == c_LAST_IDX) begin
                        r_state     <= RUN;
                        r_sweep_idx <= '0;
                    end else begin
                        r_sweep_idx <= r_sweep_idx + 1'b1;
                    end
                end
                RUN: begin
                    if (w_fl_acc) begin
                        r_state     <= INIT;
                        r_sweep_idx <= '0;
                    end
                end
                default: begin
                    r_state     <= INIT;
                    r_sweep_idx <= '0;
                end
            endcase
        end
    end

    // The SRAM returns pre-write data on a collision, so remember which ways
    // the same-cycle write replaces and overlay them in the response cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_lk_tag     <= '0;
            r_fwd_mask   <= '0;
            r_fwd_data   <= '0;
        end else begin
            r_resp_valid <= w_lk_acc;
            if (w_lk_acc) begin
                r_lk_tag   <= bus.lk_tag;
                r_fwd_mask <= (w_wr_acc && (bus.wr_idx == bus.lk_idx)) ? bus.wr_way_oh : '0;
                r_fwd_data <= bus.wr_data;
            end
        end
    end

    assign sram_r_addr = bus.lk_idx;

    assign sram_w_en     = !w_run || w_wr_acc;
    assign sram_w_addr   = w_run ? bus.wr_idx    : r_sweep_idx;
    assign w_wr_word     = w_run ? bus.wr_data   : '0;
    assign sram_w_maskOH = w_run ? bus.wr_way_oh : {WAYS{1'b1}};
    assign sram_w_data_0 = w_wr_word;
    assign sram_w_data_1 = w_wr_word;
    assign sram_w_data_2 = w_wr_word;
    assign sram_w_data_3 = w_wr_word;

    assign w_rd_data[0] = sram_r_data_0;
    assign w_rd_data[1] = sram_r_data_1;
    assign w_rd_data[2] = sram_r_data_2;
    assign w_rd_data[3] = sram_r_data_3;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic [TAG_W-1:0] w_entry;

        // Response data is held at zero outside the response cycle.
        assign w_entry = !r_resp_valid ? '0 :
                         (r_fwd_mask[g] ? r_fwd_data : w_rd_data[g]);
        assign w_resp_data[g*TAG_W +: TAG_W] = w_entry;

        tag_way_compare u_cmp (
            .i_entry (w_entry),
            .i_tag   (r_lk_tag),
            .o_hit   (w_hit[g])
        );
    end

    assign bus.lk_resp_valid = r_resp_valid;
    assign bus.lk_resp_data  = w_resp_data;
    assign bus.lk_hit_oh     = w_hit;

endmodule
`default_nettype wire
